// File: rtl/sevenseg_scan_decoder_if.sv
// Frame output channel of the scanned 7-segment receiver: decoded digits, masks and valid/ready.
interface sevenseg_scan_decoder_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] bcd_out;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   err_mask;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output bcd_out, blank_mask, err_mask, out_valid,
    input  out_ready
  );

  modport slave (
    input  bcd_out, blank_mask, err_mask, out_valid,
    output out_ready
  );
endinterface

// File: rtl/sevenseg_scan_decoder.sv
// Samples a multiplexed 7-segment bus, debounces each digit dwell, decodes it to BCD and
// emits one frame per complete scan over a valid/ready channel with sticky overrun.
module sevenseg_scan_decoder #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [NUM_DIGITS-1:0] dig_en,
  input  logic                  clr_overrun,
  output logic                  overrun,
  sevenseg_scan_decoder_if.master frm
);
  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 1);

  typedef enum logic {WAIT_STABLE, CAPTURED} dwell_t;
  typedef enum logic {COLLECT, PRESENT} frame_t;

  // Returns {blank, err, code}
  function automatic logic [5:0] decode(input logic [6:0] s);
    case (s)
      7'b1111110: decode = 6'h00;
      7'b0110000: decode = 6'h01;
      7'b1101101: decode = 6'h02;
      7'b1111001: decode = 6'h03;
      7'b0110011: decode = 6'h04;
      7'b1011011: decode = 6'h05;
      7'b1011111: decode = 6'h06;
      7'b1110000: decode = 6'h07;
      7'b1111111: decode = 6'h08;
      7'b1111011: decode = 6'h09;
      7'b0000000: decode = {2'b10, 4'hF};
      default:    decode = {2'b01, 4'hE};
    endcase
  endfunction

  logic [6:0]              seg_q, seg_prev_q;
  logic [NUM_DIGITS-1:0]   dig_q, dig_prev_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  dwell_t                  dwell_q, dwell_d;
  logic [4*NUM_DIGITS-1:0] code_q, code_d, snap_code_q, bcd_q;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d, snap_blank_q, bmask_q;
  logic [NUM_DIGITS-1:0]   err_q, err_d, snap_err_q, emask_q;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    done_q;
  frame_t                  frame_q, frame_d;
  logic                    overrun_q, overrun_d;

  logic       onehot, same, capture, full, load, handoff, drop;
  logic [CW-1:0] run;
  logic [5:0] dec;

  always_comb begin
    onehot  = (dig_q != '0) && ((dig_q & (dig_q - NUM_DIGITS'(1))) == '0);
    same    = (seg_q == seg_prev_q) && (dig_q == dig_prev_q);
    run     = '0;
    if (onehot && same) run = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    // A changed sample restarts the dwell even from CAPTURED, so it may capture at once when STABLE_CYCLES=1
    capture = onehot && (!same || dwell_q == WAIT_STABLE) && (run >= CNT_CAP);
    cnt_d   = run;
    if (!onehot)     dwell_d = WAIT_STABLE;
    else if (capture) dwell_d = CAPTURED;
    else if (!same)   dwell_d = WAIT_STABLE;
    else              dwell_d = dwell_q;

    dec     = decode(seg_q);
    code_d  = code_q;
    blank_d = blank_q;
    err_d   = err_q;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (capture && dig_q[i]) begin
        code_d[4*i +: 4] = dec[3:0];
        blank_d[i]       = dec[5];
        err_d[i]         = dec[4];
      end
    end
    full   = &seen_q;
    seen_d = full ? '0 : seen_q;
    if (capture) seen_d = seen_d | dig_q;

    handoff   = (frame_q == PRESENT) && frm.out_ready;
    load      = done_q && ((frame_q == COLLECT) || frm.out_ready);
    drop      = done_q && !load;
    if (load)         frame_d = PRESENT;
    else if (handoff) frame_d = COLLECT;
    else              frame_d = frame_q;
    overrun_d = (overrun_q && !clr_overrun) || drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q        <= '0;
      seg_prev_q   <= '0;
      dig_q        <= '0;
      dig_prev_q   <= '0;
      cnt_q        <= '0;
      dwell_q      <= WAIT_STABLE;
      code_q       <= '0;
      blank_q      <= '0;
      err_q        <= '0;
      seen_q       <= '0;
      done_q       <= 1'b0;
      snap_code_q  <= '0;
      snap_blank_q <= '0;
      snap_err_q   <= '0;
      frame_q      <= COLLECT;
      bcd_q        <= '0;
      bmask_q      <= '0;
      emask_q      <= '0;
      overrun_q    <= 1'b0;
    end else begin
      seg_q      <= seg_in;
      dig_q      <= dig_en;
      seg_prev_q <= seg_q;
      dig_prev_q <= dig_q;
      cnt_q      <= cnt_d;
      dwell_q    <= dwell_d;
      code_q     <= code_d;
      blank_q    <= blank_d;
      err_q      <= err_d;
      seen_q     <= seen_d;
      // Snapshot decouples the finished frame from captures already landing for the next one
      done_q     <= full;
      if (full) begin
        snap_code_q  <= code_q;
        snap_blank_q <= blank_q;
        snap_err_q   <= err_q;
      end
      frame_q   <= frame_d;
      overrun_q <= overrun_d;
      if (load) begin
        bcd_q   <= snap_code_q;
        bmask_q <= snap_blank_q;
        emask_q <= snap_err_q;
      end
    end
  end

  assign frm.bcd_out    = bcd_q;
  assign frm.blank_mask = bmask_q;
  assign frm.err_mask   = emask_q;
  assign frm.out_valid  = (frame_q == PRESENT);
  assign overrun        = overrun_q;
endmodule
